// File: rtl/seq_mag_cmp.sv
// seq_mag_cmp: iterative magnitude comparator.
// Compares two WIDTH-bit operands CHUNK bits per clock, most-significant
// chunk first, and stops at the first chunk that differs. Two's-complement
// operands are handled by flipping the sign bit of both operands at capture
// time, after which the scan is a plain unsigned compare.
module seq_mag_cmp #(
    parameter  int WIDTH  = 64,
    parameter  int CHUNK  = 8,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW     = $clog2(NCHUNK) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             OPGTQ,
    output logic             OPEQQ,
    output logic             OPLTQ,
    output logic [CW-1:0]    cycles
);

    // Chunk index width; at least one bit so a single-chunk build still has a register.
    localparam int            IW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);
    localparam logic [CW-1:0] CYC_ALL = CW'(NCHUNK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Flip the sign bit when comparing signed values: this maps the
    // two's-complement range monotonically onto the unsigned range.
    function automatic logic [WIDTH-1:0] bias_operand(
        input logic [WIDTH-1:0] v,
        input logic             is_signed
    );
        logic [WIDTH-1:0] r;
        r          = v;
        r[WIDTH-1] = v[WIDTH-1] ^ is_signed;
        return r;
    endfunction

    // Select chunk i of v; written as a constant-offset mux so every slice is static.
    function automatic logic [CHUNK-1:0] chunk_sel(
        input logic [WIDTH-1:0] v,
        input logic [IW-1:0]    i
    );
        logic [CHUNK-1:0] r;
        r = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (i == IW'(k)) begin
                r = v[k*CHUNK +: CHUNK];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           state_nx_s;

    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] q_r;
    logic [IW-1:0]    idx_r;
    logic [CW-1:0]    cnt_r;

    logic             accept_s;
    logic [CHUNK-1:0] p_chunk_s;
    logic [CHUNK-1:0] q_chunk_s;
    logic             chunk_gt_s;
    logic             chunk_lt_s;
    logic             last_s;
    logic [CW-1:0]    cnt_inc_s;

    logic             busy_r;
    logic             done_r;
    logic             gt_r;
    logic             eq_r;
    logic             lt_r;
    logic [CW-1:0]    cycles_r;

    logic             busy_nx_s;
    logic             done_nx_s;
    logic             gt_nx_s;
    logic             eq_nx_s;
    logic             lt_nx_s;
    logic [CW-1:0]    cycles_nx_s;

    // A request is taken whenever no scan is running, including the DONE cycle.
    assign accept_s = start & (state_r != ST_SCAN);

    // Compare the chunk currently pointed to and work out the running count.
    always_comb begin
        p_chunk_s  = chunk_sel(p_r, idx_r);
        q_chunk_s  = chunk_sel(q_r, idx_r);
        chunk_gt_s = (p_chunk_s > q_chunk_s);
        chunk_lt_s = (p_chunk_s < q_chunk_s);
        last_s     = (idx_r == '0);
        cnt_inc_s  = cnt_r + CW'(1'b1);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: scan until a chunk differs or chunk 0 has been compared.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_SCAN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (chunk_gt_s || chunk_lt_s || last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nx_s = ST_SCAN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered status and result outputs.
    always_comb begin
        busy_nx_s   = (state_nx_s == ST_SCAN);
        done_nx_s   = (state_nx_s == ST_DONE);
        gt_nx_s     = gt_r;
        eq_nx_s     = eq_r;
        lt_nx_s     = lt_r;
        cycles_nx_s = cycles_r;
        if ((state_r == ST_SCAN) && (state_nx_s == ST_DONE)) begin
            if (chunk_gt_s) begin
                gt_nx_s     = 1'b1;
                eq_nx_s     = 1'b0;
                lt_nx_s     = 1'b0;
                cycles_nx_s = cnt_inc_s;
            end else if (chunk_lt_s) begin
                gt_nx_s     = 1'b0;
                eq_nx_s     = 1'b0;
                lt_nx_s     = 1'b1;
                cycles_nx_s = cnt_inc_s;
            end else begin
                gt_nx_s     = 1'b0;
                eq_nx_s     = 1'b1;
                lt_nx_s     = 1'b0;
                cycles_nx_s = CYC_ALL;
            end
        end else begin
            // Results are held from one done pulse to the next.
            gt_nx_s     = gt_r;
            eq_nx_s     = eq_r;
            lt_nx_s     = lt_r;
            cycles_nx_s = cycles_r;
        end
    end

    // Output registers: no input reaches an output without passing a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            gt_r     <= 1'b0;
            eq_r     <= 1'b0;
            lt_r     <= 1'b0;
            cycles_r <= '0;
        end else begin
            busy_r   <= busy_nx_s;
            done_r   <= done_nx_s;
            gt_r     <= gt_nx_s;
            eq_r     <= eq_nx_s;
            lt_r     <= lt_nx_s;
            cycles_r <= cycles_nx_s;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Operand capture on acceptance, then chunk pointer and count advance during the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r   <= '0;
            q_r   <= '0;
            idx_r <= '0;
            cnt_r <= '0;
        end else if (accept_s) begin
            p_r   <= bias_operand(P, sgn);
            q_r   <= bias_operand(Q, sgn);
            idx_r <= IDX_TOP;
            cnt_r <= '0;
        end else if (state_r == ST_SCAN) begin
            cnt_r <= cnt_inc_s;
            if (state_nx_s == ST_SCAN) begin
                idx_r <= idx_r - IW'(1'b1);
            end else begin
                idx_r <= idx_r;
            end
        end else begin
            p_r   <= p_r;
            q_r   <= q_r;
            idx_r <= idx_r;
            cnt_r <= cnt_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign OPGTQ  = gt_r;
    assign OPEQQ  = eq_r;
    assign OPLTQ  = lt_r;
    assign cycles = cycles_r;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Scoreboard bench for seq_mag_cmp: three instances (64/8, 32/16, 32/32).
// The driver pushes the hand-computed result, chunk count and the cycle on
// which done must appear; per-instance monitors pop and compare on done.
module tb_seq_mag_cmp;

    typedef struct {
        logic [2:0] res;      // {GT, EQ, LT}
        int         k;        // expected cycles output / latency
        int         done_at;  // cycle counter value when done must be seen
    } exp_t;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    // Instance 0: WIDTH=64, CHUNK=8
    logic        start0 = 1'b0, sgn0 = 1'b0;
    logic [63:0] p0 = '0, q0 = '0;
    logic        busy0, done0, gt0, eq0, lt0;
    logic [3:0]  ncy0;
    // Instance 1: WIDTH=32, CHUNK=16
    logic        start1 = 1'b0, sgn1 = 1'b0;
    logic [31:0] p1 = '0, q1 = '0;
    logic        busy1, done1, gt1, eq1, lt1;
    logic [1:0]  ncy1;
    // Instance 2: WIDTH=32, CHUNK=32
    logic        start2 = 1'b0, sgn2 = 1'b0;
    logic [31:0] p2 = '0, q2 = '0;
    logic        busy2, done2, gt2, eq2, lt2;
    logic [0:0]  ncy2;

    seq_mag_cmp #(.WIDTH(64), .CHUNK(8)) u64 (
        .clk(clk), .rst(rst), .start(start0), .sgn(sgn0), .P(p0), .Q(q0),
        .busy(busy0), .done(done0), .OPGTQ(gt0), .OPEQQ(eq0), .OPLTQ(lt0), .cycles(ncy0)
    );
    seq_mag_cmp #(.WIDTH(32), .CHUNK(16)) u32a (
        .clk(clk), .rst(rst), .start(start1), .sgn(sgn1), .P(p1), .Q(q1),
        .busy(busy1), .done(done1), .OPGTQ(gt1), .OPEQQ(eq1), .OPLTQ(lt1), .cycles(ncy1)
    );
    seq_mag_cmp #(.WIDTH(32), .CHUNK(32)) u32b (
        .clk(clk), .rst(rst), .start(start2), .sgn(sgn2), .P(p2), .Q(q2),
        .busy(busy2), .done(done2), .OPGTQ(gt2), .OPEQQ(eq2), .OPLTQ(lt2), .cycles(ncy2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spurious(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: done pulse with no request outstanding", name);
    endtask

    // Monitors: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (done0) begin
            if (sb0.size() == 0) begin
                spurious("u64 done");
            end else begin
                e = sb0.pop_front();
                check("u64 result", int'({gt0, eq0, lt0}), int'(e.res));
                check("u64 cycles", int'(ncy0), e.k);
                check("u64 latency", cyc, e.done_at);
                check("u64 busy at done", int'(busy0), 0);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1) begin
            if (sb1.size() == 0) begin
                spurious("u32a done");
            end else begin
                e = sb1.pop_front();
                check("u32a result", int'({gt1, eq1, lt1}), int'(e.res));
                check("u32a cycles", int'(ncy1), e.k);
                check("u32a latency", cyc, e.done_at);
                check("u32a busy at done", int'(busy1), 0);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (done2) begin
            if (sb2.size() == 0) begin
                spurious("u32b done");
            end else begin
                e = sb2.pop_front();
                check("u32b result", int'({gt2, eq2, lt2}), int'(e.res));
                check("u32b cycles", int'(ncy2), e.k);
                check("u32b latency", cyc, e.done_at);
                check("u32b busy at done", int'(busy2), 0);
            end
        end
    end

    // Drive one request at a negedge; start is dropped one cycle later.
    task automatic issue(input int inst, input logic [63:0] p, input logic [63:0] q,
                         input logic s, input logic [2:0] res, input int k, input bit push);
        exp_t e;
        e.res     = res;
        e.k       = k;
        e.done_at = cyc + 1 + k;
        case (inst)
            0: begin
                start0 = 1'b1; sgn0 = s; p0 = p; q0 = q;
                if (push) sb0.push_back(e);
            end
            1: begin
                start1 = 1'b1; sgn1 = s; p1 = p[31:0]; q1 = q[31:0];
                if (push) sb1.push_back(e);
            end
            default: begin
                start2 = 1'b1; sgn2 = s; p2 = p[31:0]; q2 = q[31:0];
                if (push) sb2.push_back(e);
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Wait (bounded) until every expectation has been consumed.
    task automatic drain();
        int n;
        n = 0;
        while ((sb0.size() + sb1.size() + sb2.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb0.size() + sb1.size() + sb2.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_idle(input int inst);
        case (inst)
            0: begin
                check("u64 idle busy", int'(busy0), 0);
                check("u64 idle done", int'(done0), 0);
                check("u64 idle result", int'({gt0, eq0, lt0}), 0);
                check("u64 idle cycles", int'(ncy0), 0);
            end
            1: begin
                check("u32a idle busy", int'(busy1), 0);
                check("u32a idle done", int'(done1), 0);
                check("u32a idle result", int'({gt1, eq1, lt1}), 0);
                check("u32a idle cycles", int'(ncy1), 0);
            end
            default: begin
                check("u32b idle busy", int'(busy2), 0);
                check("u32b idle done", int'(done2), 0);
                check("u32b idle result", int'({gt2, eq2, lt2}), 0);
                check("u32b idle cycles", int'(ncy2), 0);
            end
        endcase
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        int   c0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle(0);
        check_idle(1);
        check_idle(2);
        rst = 1'b0;
        @(negedge clk);
        check_idle(0);

        // 64/8 directed vectors
        issue(0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, R_EQ, 8, 1'b1); drain();
        issue(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, R_GT, 1, 1'b1); drain();
        issue(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, R_LT, 1, 1'b1); drain();
        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, R_GT, 8, 1'b1); drain();
        issue(0, 64'd5,                   64'd6,                   1'b0, R_LT, 8, 1'b1); drain();
        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   1'b1, R_LT, 1, 1'b1); drain();
        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   1'b0, R_GT, 1, 1'b1); drain();
        issue(0, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_00FF, 1'b0, R_GT, 7, 1'b1); drain();

        // Start while busy is ignored; held start is taken in the DONE cycle.
        c0 = cyc;
        issue(0, 64'd1, 64'd2, 1'b0, R_LT, 8, 1'b1);
        start0 = 1'b1; p0 = 64'd9; q0 = 64'd2;
        @(negedge clk);
        p0 = 64'd3; q0 = 64'd3;
        e.res = R_EQ; e.k = 8; e.done_at = c0 + 18;
        sb0.push_back(e);
        repeat (8) @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        check("u64 result held during scan", int'({gt0, eq0, lt0}), int'(R_LT));
        check("u64 busy during scan", int'(busy0), 1);
        drain();

        // Reset mid-scan aborts without a done pulse.
        issue(0, 64'd0, 64'd0, 1'b0, R_EQ, 8, 1'b0);
        repeat (2) @(negedge clk);
        check("u64 busy before abort", int'(busy0), 1);
        rst = 1'b1;
        #1;
        check_idle(0);
        @(negedge clk);
        rst = 1'b0;
        check_idle(0);
        repeat (12) @(negedge clk);
        check_idle(0);
        issue(0, 64'h0000_0100_0000_0000, 64'h0000_00FF_FFFF_FFFF, 1'b0, R_GT, 3, 1'b1); drain();

        // 32/16
        issue(1, 64'h0001_0000, 64'h0000_FFFF, 1'b0, R_GT, 1, 1'b1); drain();
        issue(1, 64'h1234_5678, 64'h1234_5678, 1'b0, R_EQ, 2, 1'b1); drain();
        issue(1, 64'h8000_0000, 64'h0000_0001, 1'b1, R_LT, 1, 1'b1); drain();
        issue(1, 64'h0000_0001, 64'h0000_0002, 1'b0, R_LT, 2, 1'b1); drain();

        // 32/32: single-cycle scan
        issue(2, 64'hDEAD_BEEF, 64'h1234_5678, 1'b0, R_GT, 1, 1'b1); drain();
        issue(2, 64'hDEAD_BEEF, 64'h1234_5678, 1'b1, R_LT, 1, 1'b1); drain();
        issue(2, 64'hCAFE_F00D, 64'hCAFE_F00D, 1'b0, R_EQ, 1, 1'b1); drain();

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
